// File: rtl/duc_pkg.sv
// duc_pkg: shared types and helpers for the DUC rate sequencer.
// Optional feature macro used by the sequencer: DUC_RATE_CTRL_FLUSH_EN.
package duc_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    PURGE = 2'd3
  } duc_rate_state_e;

  // Wide container for rate codes so helpers are independent of RATE_W.
  typedef logic [7:0] rate_t;

  localparam int unsigned MASK_W = 32;

  // Bit i set when stage i is bypassed, i.e. i >= rate.
  function automatic logic [MASK_W-1:0] bypass_mask(input rate_t rate);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      m[i] = (i >= 32'(rate));
    end
    return m;
  endfunction

endpackage

// File: rtl/duc_outstanding_cnt.sv
// duc_outstanding_cnt: counts output samples still owed by the interpolator
// chain and reports whether another head sample fits under the credit limit.
module duc_outstanding_cnt #(
  parameter int unsigned CNT_W           = 7,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             head_fire,
  input  logic             tail_fire,
  input  logic [CNT_W-1:0] inc,
  output logic [CNT_W-1:0] cnt,
  output logic             credit_ok
);

  logic [CNT_W:0]   sum_head;
  logic [CNT_W-1:0] cnt_next;

  // Credit check and combined add/subtract update.
  always_comb begin
    sum_head  = {1'b0, cnt} + {1'b0, inc};
    credit_ok = (sum_head <= (CNT_W+1)'(MAX_OUTSTANDING));
    cnt_next  = cnt;
    if (head_fire) cnt_next = cnt_next + inc;
    if (tail_fire) cnt_next = cnt_next - CNT_W'(1);
  end

  // Outstanding-sample register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) cnt <= '0;
    else         cnt <= cnt_next;
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!arst_n)
    !(tail_fire && cnt == '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n)
    32'(cnt) <= MAX_OUTSTANDING);

endmodule

// File: rtl/duc_rate_ctrl.sv
// duc_rate_ctrl: rate sequencer for a cascade of x2 interpolator stages.
// Drains the chain before applying a new rate. Define DUC_RATE_CTRL_FLUSH_EN
// to zero-flush the filter delay lines after every rate change.
module duc_rate_ctrl
  import duc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned N_STAGES        = 3,
  parameter int unsigned RATE_W          = $clog2(N_STAGES+1),
  parameter int unsigned RESET_RATE      = 3,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned FLUSH_LEN       = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [RATE_W-1:0]     cfg_rate_in,
  input  logic                  cfg_valid_in,
  output logic                  cfg_ready_out,
  input  logic [DATA_WIDTH-1:0] src_data_in,
  input  logic                  src_valid_in,
  output logic                  src_ready_out,
  output logic [DATA_WIDTH-1:0] chain_data_out,
  output logic                  chain_valid_out,
  input  logic                  chain_ready_in,
  input  logic                  tail_valid_in,
  output logic                  tail_ready_out,
  output logic                  dst_valid_out,
  input  logic                  dst_ready_in,
  output logic [N_STAGES-1:0]   stage_bypass_out,
  output logic [RATE_W-1:0]     rate_out,
  output logic                  busy_out
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam logic [N_STAGES-1:0] RESET_BYPASS =
    N_STAGES'(bypass_mask(rate_t'(RESET_RATE)));

  duc_rate_state_e     state, state_next;
  logic [RATE_W-1:0]   rate_q, pending_q, rate_clamped;
  logic [N_STAGES-1:0] bypass_q;
  logic [CNT_W-1:0]    cnt, inc;
  logic                credit_ok, head_fire, tail_fire, load_rate;

  assign head_fire    = chain_valid_out & chain_ready_in;
  assign tail_fire    = tail_valid_in & tail_ready_out;
  assign inc          = CNT_W'(1) << rate_q;
  assign rate_clamped = (32'(cfg_rate_in) > N_STAGES) ? RATE_W'(N_STAGES) : cfg_rate_in;
  assign rate_out         = rate_q;
  assign stage_bypass_out = bypass_q;
  assign busy_out         = (state != RUN);

  duc_outstanding_cnt #(
    .CNT_W           (CNT_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_cnt (
    .clk       (clk),
    .arst_n    (arst_n),
    .head_fire (head_fire),
    .tail_fire (tail_fire),
    .inc       (inc),
    .cnt       (cnt),
    .credit_ok (credit_ok)
  );

`ifdef DUC_RATE_CTRL_FLUSH_EN
  localparam int unsigned FL_W = $clog2(FLUSH_LEN+1);
  logic [FL_W-1:0] flush_cnt;
  logic            flush_last;

  assign flush_last = (flush_cnt == FL_W'(FLUSH_LEN-1));

  // Counts zero-sample injections; restarted at every rate load.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                          flush_cnt <= '0;
    else if (load_rate)                   flush_cnt <= '0;
    else if (state == FLUSH && head_fire) flush_cnt <= flush_cnt + FL_W'(1);
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= RUN;
    else         state <= state_next;
  end

  // Next-state and handshake gating per state.
  always_comb begin
    state_next      = state;
    chain_data_out  = src_data_in;
    chain_valid_out = 1'b0;
    src_ready_out   = 1'b0;
    dst_valid_out   = tail_valid_in;
    tail_ready_out  = dst_ready_in;
    cfg_ready_out   = 1'b0;
    load_rate       = 1'b0;
    case (state)
      RUN: begin
        chain_valid_out = src_valid_in & credit_ok;
        src_ready_out   = chain_ready_in & credit_ok;
        cfg_ready_out   = 1'b1;
        if (cfg_valid_in) state_next = DRAIN;
      end
      DRAIN: begin
        if (cnt == '0) begin
          load_rate = 1'b1;
`ifdef DUC_RATE_CTRL_FLUSH_EN
          state_next = FLUSH;
`else
          state_next = RUN;
`endif
        end
      end
`ifdef DUC_RATE_CTRL_FLUSH_EN
      FLUSH: begin
        // Injections still honour the credit limit so cnt cannot overflow
        // at high rates; the discarded tail frees credit each cycle.
        chain_data_out  = '0;
        chain_valid_out = credit_ok;
        dst_valid_out   = 1'b0;
        tail_ready_out  = 1'b1;
        if (credit_ok && chain_ready_in && flush_last) state_next = PURGE;
      end
      PURGE: begin
        dst_valid_out  = 1'b0;
        tail_ready_out = 1'b1;
        if (cnt == '0) state_next = RUN;
      end
`endif
      default: state_next = RUN;
    endcase
  end

  // Pending / applied rate and registered bypass bits.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rate_q    <= RATE_W'(RESET_RATE);
      pending_q <= RATE_W'(RESET_RATE);
      bypass_q  <= RESET_BYPASS;
    end else begin
      if (state == RUN && cfg_valid_in) pending_q <= rate_clamped;
      if (load_rate) begin
        rate_q   <= pending_q;
        bypass_q <= N_STAGES'(bypass_mask(rate_t'(pending_q)));
      end
    end
  end

endmodule

// File: tb/tb_duc_rate_ctrl.sv
// tb_duc_rate_ctrl: directed, table-driven bench for duc_rate_ctrl with a
// behavioural interpolator-chain model (each head sample yields 2^active
// stages tail samples). Macro DUC_RATE_CTRL_FLUSH_EN selects expectations.
module tb_duc_rate_ctrl;
  import duc_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned NS = 3;
  localparam int unsigned RW = 2;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [RW-1:0] cfg_rate_in = '0;
  logic          cfg_valid_in = 1'b0, cfg_ready_out;
  logic [DW-1:0] src_data_in = '0;
  logic          src_valid_in = 1'b0, src_ready_out;
  logic [DW-1:0] chain_data_out;
  logic          chain_valid_out, chain_ready_in = 1'b0;
  logic          tail_valid_in, tail_ready_out;
  logic          dst_valid_out, dst_ready_in = 1'b0;
  logic [NS-1:0] stage_bypass_out;
  logic [RW-1:0] rate_out;
  logic          busy_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  duc_rate_ctrl #(
    .DATA_WIDTH      (DW),
    .N_STAGES        (NS),
    .RATE_W          (RW),
    .RESET_RATE      (3),
    .MAX_OUTSTANDING (64),
    .FLUSH_LEN       (32)
  ) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .cfg_rate_in      (cfg_rate_in),
    .cfg_valid_in     (cfg_valid_in),
    .cfg_ready_out    (cfg_ready_out),
    .src_data_in      (src_data_in),
    .src_valid_in     (src_valid_in),
    .src_ready_out    (src_ready_out),
    .chain_data_out   (chain_data_out),
    .chain_valid_out  (chain_valid_out),
    .chain_ready_in   (chain_ready_in),
    .tail_valid_in    (tail_valid_in),
    .tail_ready_out   (tail_ready_out),
    .dst_valid_out    (dst_valid_out),
    .dst_ready_in     (dst_ready_in),
    .stage_bypass_out (stage_bypass_out),
    .rate_out         (rate_out),
    .busy_out         (busy_out)
  );

  // Chain model: samples owed by the stages, driven from the head handshake.
  logic tail_en = 1'b0;
  int   owed;
  int   head_n = 0, dst_n = 0, disc_n = 0, nzflush_n = 0;

  assign tail_valid_in = tail_en && (owed != 0);

  function automatic int mult(input logic [NS-1:0] byp);
    int a = 0;
    for (int i = 0; i < NS; i++) if (!byp[i]) a++;
    return 1 << a;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) owed <= 0;
    else owed <= owed + ((chain_valid_out && chain_ready_in) ? mult(stage_bypass_out) : 0)
                      - ((tail_valid_in && tail_ready_out) ? 1 : 0);
  end

  always @(posedge clk) begin
    if (chain_valid_out && chain_ready_in) head_n <= head_n + 1;
    if (chain_valid_out && chain_ready_in && busy_out && chain_data_out != '0) nzflush_n <= nzflush_n + 1;
    if (dst_valid_out && dst_ready_in) dst_n <= dst_n + 1;
    if (tail_valid_in && tail_ready_out && !dst_valid_out) disc_n <= disc_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while ((busy_out || owed != 0) && n < budget) begin
      tick();
      n++;
    end
    check(nm, 32'(busy_out || owed != 0), 32'd0);
  endtask

  task automatic req_rate(input logic [RW-1:0] r);
    cfg_rate_in  = r;
    cfg_valid_in = 1'b1;
    tick();
    cfg_valid_in = 1'b0;
  endtask

  typedef struct {
    logic          sv, cr, dr;
    logic [DW-1:0] d;
    logic          ecv, esr, etr;
  } vec_t;

  vec_t vt[5];

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int h0, d0, x0, z0, peak;

    vt[0] = '{1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 16'hABCD, 1'b1, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 1'b0, 16'h0F0F, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b1, 1'b1};
    vt[4] = '{1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    check("rst_bypass", 32'(stage_bypass_out), 32'd0);
    check("rst_rate", 32'(rate_out), 32'd3);
    check("rst_cfg_ready", 32'(cfg_ready_out), 32'd1);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_chain_valid", 32'(chain_valid_out), 32'd0);
    check("rst_dst_valid", 32'(dst_valid_out), 32'd0);
    check("rst_cnt", 32'(dut.cnt), 32'd0);
    tick();

    // RUN-state gating vectors at rate 3, tail held off
    for (int i = 0; i < 5; i++) begin
      src_valid_in   = vt[i].sv;
      chain_ready_in = vt[i].cr;
      dst_ready_in   = vt[i].dr;
      src_data_in    = vt[i].d;
      @(negedge clk);
      check("vec_chain_valid", 32'(chain_valid_out), 32'(vt[i].ecv));
      check("vec_src_ready", 32'(src_ready_out), 32'(vt[i].esr));
      check("vec_tail_ready", 32'(tail_ready_out), 32'(vt[i].etr));
      check("vec_chain_data", 32'(chain_data_out), 32'(vt[i].d));
      check("vec_dst_valid", 32'(dst_valid_out), 32'd0);
      tick();
    end
    src_valid_in = 1'b0;
    chain_ready_in = 1'b0;
    @(negedge clk);
    check("vec_cnt", 32'(dut.cnt), 32'd16);
    tick();
    d0 = dst_n;
    tail_en = 1'b1;
    dst_ready_in = 1'b1;
    wait_idle("vec_drain_timeout", 200);
    check("vec_dst_count", 32'(dst_n - d0), 32'd16);

    // Credit limit at rate 3 with downstream stalled
    dst_ready_in = 1'b0;
    h0 = head_n;
    d0 = dst_n;
    src_valid_in = 1'b1;
    chain_ready_in = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    check("credit_heads", 32'(head_n - h0), 32'd8);
    check("credit_src_ready", 32'(src_ready_out), 32'd0);
    check("credit_chain_valid", 32'(chain_valid_out), 32'd0);
    check("credit_cnt", 32'(dut.cnt), 32'd64);
    tick();
    src_valid_in = 1'b0;
    dst_ready_in = 1'b1;
    wait_idle("credit_drain_timeout", 300);
    check("credit_dst_count", 32'(dst_n - d0), 32'd64);

    // Rate change 3 -> 1 with 4 samples in flight
    dst_ready_in = 1'b0;
    src_valid_in = 1'b1;
    repeat (4) tick();
    src_valid_in = 1'b0;
    @(negedge clk);
    check("chg_cnt_before", 32'(dut.cnt), 32'd32);
    tick();
    h0 = head_n; d0 = dst_n; x0 = disc_n; z0 = nzflush_n;
    dst_ready_in = 1'b1;
    req_rate(2'd1);
    @(negedge clk);
    check("chg_busy_rise", 32'(busy_out), 32'd1);
    check("chg_src_ready", 32'(src_ready_out), 32'd0);
    check("chg_cfg_ready", 32'(cfg_ready_out), 32'd0);
    check("chg_rate_hold", 32'(rate_out), 32'd3);
    tick();
    wait_idle("chg_timeout", 2000);
    check("chg_real_outputs", 32'(dst_n - d0), 32'd32);
`ifdef DUC_RATE_CTRL_FLUSH_EN
    check("chg_zero_injections", 32'(head_n - h0), 32'd32);
    check("chg_nonzero_inject", 32'(nzflush_n - z0), 32'd0);
    check("chg_discarded", 32'(disc_n - x0), 32'd64);
`else
    check("chg_head_idle", 32'(head_n - h0), 32'd0);
    check("chg_discarded", 32'(disc_n - x0), 32'd0);
`endif
    @(negedge clk);
    check("chg_rate", 32'(rate_out), 32'd1);
    check("chg_bypass", 32'(stage_bypass_out), 32'b110);
    check("chg_busy", 32'(busy_out), 32'd0);
    check("chg_cnt_after", 32'(dut.cnt), 32'd0);
    tick();

    // Rate 1: 10 inputs, downstream always ready
    h0 = head_n; d0 = dst_n; peak = 0;
    src_valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (int'(dut.cnt) > peak) peak = int'(dut.cnt);
      tick();
    end
    src_valid_in = 1'b0;
    for (int n = 0; n < 100 && owed != 0; n++) begin
      @(negedge clk);
      if (int'(dut.cnt) > peak) peak = int'(dut.cnt);
      tick();
    end
    @(negedge clk);
    check("r1_heads", 32'(head_n - h0), 32'd10);
    check("r1_dst_count", 32'(dst_n - d0), 32'd20);
    check("r1_peak_le_20", 32'(peak <= 20), 32'd1);
    check("r1_cnt_zero", 32'(dut.cnt), 32'd0);
    tick();

    // Largest encodable code (7 truncates to 2'b11 on a 2-bit port) -> rate 3
    req_rate(2'b11);
    @(negedge clk);
    check("clamp_busy_rise", 32'(busy_out), 32'd1);
    check("clamp_rate_hold", 32'(rate_out), 32'd1);
`ifdef DUC_RATE_CTRL_FLUSH_EN
    tick();
    wait_idle("clamp_timeout", 3000);
    @(negedge clk);
`else
    // Empty chain: DRAIN lasts one cycle, new bypass visible right after
    @(negedge clk);
    check("clamp_busy_fall", 32'(busy_out), 32'd0);
`endif
    check("clamp_rate", 32'(rate_out), 32'd3);
    check("clamp_bypass", 32'(stage_bypass_out), 32'b000);
    tick();

    // Reset in the middle of a reconfiguration
    dst_ready_in = 1'b0;
    src_valid_in = 1'b1;
    repeat (2) tick();
    src_valid_in = 1'b0;
    req_rate(2'd1);
`ifdef DUC_RATE_CTRL_FLUSH_EN
    dst_ready_in = 1'b1;
    for (int n = 0; n < 200 && dut.state != FLUSH; n++) tick();
    check("rstmid_in_flush", 32'(dut.state == FLUSH), 32'd1);
    repeat (2) tick();
`else
    repeat (2) tick();
    check("rstmid_in_drain", 32'(busy_out), 32'd1);
`endif
    arst_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy_out), 32'd0);
    check("rstmid_rate", 32'(rate_out), 32'd3);
    check("rstmid_bypass", 32'(stage_bypass_out), 32'b000);
    check("rstmid_cnt", 32'(dut.cnt), 32'd0);
    tick();
    arst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rstmid_run", 32'(busy_out), 32'd0);
    check("rstmid_cfg_ready", 32'(cfg_ready_out), 32'd1);
    check("rstmid_rate_after", 32'(rate_out), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
